ps2_key_decoder: RTL and testbench

- Upstream front end of the calculator datapath: receives PS/2 keyboard frames, validates them, and translates make codes into key codes 0..14.
- Feeds the operator stage: key_code drives its data_in; key_valid drives its sel strobe.
- One key_valid pulse per accepted key press; release (break) codes are consumed internally.

---
 rtl/ps2_key_decoder_if.sv | 26 ++
 rtl/ps2_key_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// PS/2 key decoder bus: raw keyboard lines in, decoded key strobe and
// frame-error strobe out. The keyboard side (or a bench) uses the master
// modport; the decoder uses the slave modport.
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] key_code;
  logic        key_valid;
  logic        frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  key_code,
    input  key_valid,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key_code,
    output key_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the calculator datapath.
// Synchronizes and glitch-filters the PS/2 clock, receives 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and translates make codes
// into key codes 0..14 with a one-cycle key_valid strobe. Break (F0) and
// extended (E0) prefixes are consumed internally.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses keyboard
// auto-repeat makes of the key that is still held down.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              rst,
  ps2_key_decoder_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Make-code lookup; returns {hit, code}. The extended prefix plays no part.
  function automatic logic [4:0] map_code(input logic [7:0] b);
    case (b)
      8'h45, 8'h70: map_code = {1'b1, 4'd0};
      8'h16, 8'h69: map_code = {1'b1, 4'd1};
      8'h1E, 8'h72: map_code = {1'b1, 4'd2};
      8'h26, 8'h7A: map_code = {1'b1, 4'd3};
      8'h25, 8'h6B: map_code = {1'b1, 4'd4};
      8'h2E, 8'h73: map_code = {1'b1, 4'd5};
      8'h36, 8'h74: map_code = {1'b1, 4'd6};
      8'h3D, 8'h6C: map_code = {1'b1, 4'd7};
      8'h3E, 8'h75: map_code = {1'b1, 4'd8};
      8'h46, 8'h7D: map_code = {1'b1, 4'd9};
      8'h79, 8'h55: map_code = {1'b1, 4'd10};
      8'h7B, 8'h4E: map_code = {1'b1, 4'd11};
      8'h7C:        map_code = {1'b1, 4'd12};
      8'h76, 8'h66: map_code = {1'b1, 4'd13};
      8'h5A:        map_code = {1'b1, 4'd14};
      default:      map_code = 5'd0;
    endcase
  endfunction

  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_fclk, r_fclk_d;
  logic [FW-1:0] r_fcnt;
  logic          w_fall;

  state_t        r_state, w_state_n;
  logic [2:0]    r_bitcnt, w_bitcnt_n;
  logic          r_perr, w_perr_n;
  logic [TW-1:0] r_tmo, w_tmo_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          w_byte_vld_n, w_frame_err_n;
  logic          r_frame_err;

  logic [7:0]    r_byte_p0;
  logic          r_vld_p0;

  logic          r_break, r_ext;
  logic [10:0]   r_key_code_p1;
  logic          r_vld_p1;
  logic [4:0]    w_map;
  logic          w_hit;
  logic [3:0]    w_code;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic          r_held;
  logic [3:0]    r_last;
`endif

  // Stage: two-flop synchronizers for the asynchronous PS/2 lines
  always_ff @(posedge clk) begin
    r_clk_s1 <= bus.ps2_clk;
    r_clk_s2 <= r_clk_s1;
    r_dat_s1 <= bus.ps2_data;
    r_dat_s2 <= r_dat_s1;
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_fclk_d <= r_fclk;
      if (r_clk_s2 == r_fclk) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FCNT_LAST) begin
        r_fclk <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_fall = r_fclk_d & ~r_fclk;

  // Receive FSM state register and handoff strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_perr      <= 1'b0;
      r_tmo       <= '0;
      r_vld_p0    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bitcnt    <= w_bitcnt_n;
      r_perr      <= w_perr_n;
      r_tmo       <= w_tmo_n;
      r_vld_p0    <= w_byte_vld_n;
      r_frame_err <= w_frame_err_n;
    end
  end

  // Receive FSM next-state: bit sampling on filtered falling edges, timeout abort
  always_comb begin
    w_state_n     = r_state;
    w_bitcnt_n    = r_bitcnt;
    w_perr_n      = r_perr;
    w_shift_n     = r_shift;
    w_byte_vld_n  = 1'b0;
    w_frame_err_n = 1'b0;
    w_tmo_n       = (r_state == IDLE) ? '0 : r_tmo + 1'b1;

    if (r_state != IDLE && r_tmo == TMO_LIMIT) begin
      w_state_n     = IDLE;
      w_frame_err_n = 1'b1;
      w_tmo_n       = '0;
    end else if (w_fall) begin
      w_tmo_n = '0;
      case (r_state)
        IDLE: begin
          if (!r_dat_s2) begin
            w_state_n  = DATA;
            w_bitcnt_n = '0;
            w_perr_n   = 1'b0;
          end
        end
        DATA: begin
          w_shift_n  = {r_dat_s2, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_n = PARITY;
        end
        PARITY: begin
          w_perr_n  = ~(^{r_shift, r_dat_s2});
          w_state_n = STOP;
        end
        STOP: begin
          w_state_n = IDLE;
          if (!r_dat_s2 || r_perr) w_frame_err_n = 1'b1;
          else                     w_byte_vld_n  = 1'b1;
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // Stage p0: shift register and completed-byte handoff
  always_ff @(posedge clk) begin
    r_shift <= w_shift_n;
    if (w_byte_vld_n) r_byte_p0 <= r_shift;
  end

  assign w_map  = map_code(r_byte_p0);
  assign w_hit  = w_map[4];
  assign w_code = w_map[3:0];

  // Stage p1: prefix tracking, make-code translation and key strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_break       <= 1'b0;
      r_ext         <= 1'b0;
      r_vld_p1      <= 1'b0;
      r_key_code_p1 <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      r_held        <= 1'b0;
`endif
    end else begin
      r_vld_p1 <= 1'b0;
      if (r_vld_p0) begin
        if (r_byte_p0 == 8'hF0) begin
          r_break <= 1'b1;
        end else if (r_byte_p0 == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_break) begin
          // Released key: consume the code, drop both prefixes
          r_break <= 1'b0;
          if (r_ext) r_ext <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (w_hit && r_held && w_code == r_last) r_held <= 1'b0;
`endif
        end else begin
          if (r_ext) r_ext <= 1'b0;
          if (w_hit) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!(r_held && w_code == r_last)) begin
              r_vld_p1      <= 1'b1;
              r_key_code_p1 <= {7'd0, w_code};
              r_held        <= 1'b1;
              r_last        <= w_code;
            end
`else
            r_vld_p1      <= 1'b1;
            r_key_code_p1 <= {7'd0, w_code};
`endif
          end
        end
      end
    end
  end

  assign bus.key_code  = r_key_code_p1;
  assign bus.key_valid = r_vld_p1;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frame table, hand-written corner
// sequences (latency, idle noise, timeout, reset mid-frame) and random
// frames checked against a byte-level behavioural model.
module tb_ps2_key_decoder;

  localparam int FL = 4;
  localparam int TO = 300;
  localparam int H  = 10;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit TM = 1'b1;
`else
  localparam bit TM = 1'b0;
`endif
  localparam int REP = TM ? 0 : 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_kv = 0, n_fe = 0, n_both = 0, kv_lat = 0;

  always @(negedge clk) begin
    if (bus.key_valid) n_kv++;
    if (bus.frame_err) n_fe++;
    if (bus.key_valid && bus.frame_err) n_both++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", n_errors);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (byte level) ----------------
  logic [7:0] top_row [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] keypad  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  logic [7:0] ops     [8]  = '{8'h79, 8'h55, 8'h7B, 8'h4E, 8'h7C, 8'h76, 8'h66, 8'h5A};
  int         ops_code[8]  = '{10, 10, 11, 11, 12, 13, 13, 14};

  int m_code = 0;
  int m_last = -1;
  bit m_brk  = 1'b0;
  bit m_held = 1'b0;

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      if (top_row[i] == b) return i;
      if (keypad[i] == b)  return i;
    end
    for (int i = 0; i < 8; i++)
      if (ops[i] == b) return ops_code[i];
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] b, input bit bad, output int ekv, output int efe);
    int k;
    ekv = 0;
    efe = 0;
    k = lookup(b);
    if (bad) begin
      efe = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      // extended prefix: never changes the lookup
    end else if (m_brk) begin
      m_brk = 1'b0;
      if (k >= 0 && k == m_last) m_held = 1'b0;
    end else if (k >= 0) begin
      if (!(TM && m_held && k == m_last)) begin
        ekv    = 1;
        m_code = k;
        m_last = k;
        m_held = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_code = 0;
    m_last = -1;
    m_brk  = 1'b0;
    m_held = 1'b0;
  endtask

  // ---------------- PS/2 line driver ----------------
  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input int nbits);
    logic [10:0] bits;
    bits   = {~bs, (~^b) ^ bp, b, 1'b0};
    kv_lat = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ps2_data = bits[i];
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      for (int k = 1; k <= H; k++) begin
        @(posedge clk);
        #1;
        if (bus.key_valid && kv_lat == 0) kv_lat = k;
      end
      @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit bp, input bit bs,
                           input int exp_kv, input int exp_fe, input int exp_code,
                           input string tag);
    int kv0, fe0;
    kv0 = n_kv;
    fe0 = n_fe;
    send_frame(b, bp, bs, 11);
    repeat (2 * H) @(negedge clk);
    chk({tag, " key_valid count"}, n_kv - kv0, exp_kv);
    chk({tag, " frame_err count"}, n_fe - fe0, exp_fe);
    chk({tag, " key_code"}, int'(bus.key_code), exp_code);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    int         exp_kv;
    int         exp_fe;
    int         exp_code;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int ekv, efe, kv0, fe0, r;
    logic [7:0] b;
    bit bp, bs;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    tbl.push_back('{8'h16, 1'b0, 1'b0, 1,   0, 1});
    tbl.push_back('{8'h7C, 1'b0, 1'b0, 1,   0, 12});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 0,   0, 12});
    tbl.push_back('{8'h7C, 1'b0, 1'b0, 0,   0, 12});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 0,   0, 12});
    tbl.push_back('{8'h5A, 1'b0, 1'b0, 1,   0, 14});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 0,   0, 14});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 0,   0, 14});
    tbl.push_back('{8'h5A, 1'b0, 1'b0, 0,   0, 14});
    tbl.push_back('{8'h45, 1'b1, 1'b0, 0,   1, 14});
    tbl.push_back('{8'h45, 1'b0, 1'b0, 1,   0, 0});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 0,   0, 0});
    tbl.push_back('{8'h45, 1'b0, 1'b0, 0,   0, 0});
    tbl.push_back('{8'h26, 1'b0, 1'b0, 1,   0, 3});
    tbl.push_back('{8'h26, 1'b0, 1'b0, REP, 0, 3});
    tbl.push_back('{8'h26, 1'b0, 1'b0, REP, 0, 3});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 0,   0, 3});
    tbl.push_back('{8'h26, 1'b0, 1'b0, 0,   0, 3});
    tbl.push_back('{8'h55, 1'b0, 1'b1, 0,   1, 3});
    tbl.push_back('{8'h55, 1'b0, 1'b0, 1,   0, 10});
    tbl.push_back('{8'h1C, 1'b0, 1'b0, 0,   0, 10});
    tbl.push_back('{8'h76, 1'b0, 1'b0, 1,   0, 13});
    tbl.push_back('{8'h69, 1'b0, 1'b0, 1,   0, 1});
    tbl.push_back('{8'h7D, 1'b0, 1'b0, 1,   0, 9});
    tbl.push_back('{8'h66, 1'b0, 1'b0, 1,   0, 13});

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset key_code", int'(bus.key_code), 0);
    chk("reset key_valid", int'(bus.key_valid), 0);
    chk("reset frame_err", int'(bus.frame_err), 0);
    rst = 1'b0;
    repeat (3 * H) @(negedge clk);

    // Directed table
    foreach (tbl[i]) begin
      model_step(tbl[i].b, tbl[i].bad_par | tbl[i].bad_stop, ekv, efe);
      run_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop,
                tbl[i].exp_kv, tbl[i].exp_fe, tbl[i].exp_code, $sformatf("tbl[%0d]", i));
      // 2 sync flops + FILTER_LEN filter samples + 2-cycle decode latency
      if (i == 0) chk("stop-edge to key_valid latency", kv_lat, FL + 4);
    end

    // Falling edge with data high while idle is not a start bit
    @(negedge clk);
    bus.ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (H) @(negedge clk);
    model_step(8'h5A, 1'b0, ekv, efe);
    run_frame(8'h5A, 1'b0, 1'b0, ekv, efe, m_code, "noise then 5A");
    chk("noise then 5A code", int'(bus.key_code), 14);

    // Partial frame then idle: timeout abort
    kv0 = n_kv;
    fe0 = n_fe;
    send_frame(8'h00, 1'b0, 1'b0, 5);
    repeat (TO + 100) @(negedge clk);
    chk("timeout frame_err count", n_fe - fe0, 1);
    chk("timeout key_valid count", n_kv - kv0, 0);
    model_step(8'h4E, 1'b0, ekv, efe);
    run_frame(8'h4E, 1'b0, 1'b0, ekv, efe, m_code, "after timeout 4E");
    chk("after timeout 4E code", int'(bus.key_code), 11);

    // Random frames against the model
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 7);
      if (r <= 1)      b = 8'hF0;
      else if (r == 2) b = 8'hE0;
      else if (r == 3) b = 8'($urandom_range(0, 255));
      else begin
        r = $urandom_range(0, 27);
        if (r < 10)      b = top_row[r];
        else if (r < 20) b = keypad[r - 10];
        else             b = ops[r - 20];
      end
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 14) == 0);
      model_step(b, bp | bs, ekv, efe);
      run_frame(b, bp, bs, ekv, efe, m_code, $sformatf("rand[%0d] %02h", n, b));
    end

    // Reset asserted mid-frame
    kv0 = n_kv;
    fe0 = n_fe;
    send_frame(8'h16, 1'b0, 1'b0, 6);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mid-frame rst key_code", int'(bus.key_code), 0);
    chk("mid-frame rst key_valid", int'(bus.key_valid), 0);
    chk("mid-frame rst frame_err", int'(bus.frame_err), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (TO + 100) @(negedge clk);
    chk("after rst key_valid count", n_kv - kv0, 0);
    chk("after rst frame_err count", n_fe - fe0, 0);
    model_step(8'h26, 1'b0, ekv, efe);
    run_frame(8'h26, 1'b0, 1'b0, ekv, efe, m_code, "after rst 26");
    chk("after rst 26 code", int'(bus.key_code), 3);

    chk("key_valid with frame_err same cycle", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
